adc_sim_responder: RTL and testbench

//  Synthesizable dual-channel 18-bit SAR ADC responder (slave end of the CNV/BUSY/SPI read path).

---
 rtl/adc_sim_responder.sv | 179 +++++++++++++++++
 tb/tb_adc_sim_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/adc_sim_responder.sv
// Dual-channel SAR ADC responder: CNV/BUSY handshake, then a 36-bit {ch2,ch1} frame on MISO under master SCK.
// Optional feature macro: ADC_SIM_TEST_PATTERN_EN (internal ramp replaces ch1_data/ch2_data).
module adc_sim_responder #(
    parameter int CHANNEL_DATA_WIDTH = 18,
    parameter int CONV_CYCLES        = 40,
    parameter int BIT_CNT_WIDTH      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cnv,
    input  logic                          sck,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch1_data,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch2_data,
    output logic                          adc_busy,
    output logic                          miso,
    output logic                          frame_done,
    output logic                          overrun
);
    localparam int FRAME_W = 2 * CHANNEL_DATA_WIDTH;
    localparam int CONV_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES + 1) : 1;
    localparam logic [CONV_W-1:0]        CONV_LOAD = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST  = BIT_CNT_WIDTH'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READY   = 2'd2,
        ST_SHIFT   = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic                     cnv_meta_r, cnv_sync_r, cnv_prev_r, cnv_rise_r;
    logic                     sck_meta_r, sck_sync_r, sck_prev_r, sck_rise_r, sck_fall_r;
    logic [FRAME_W-1:0]       shreg_r, shreg_nxt_s, sample_s;
    logic [CONV_W-1:0]        conv_cnt_r, conv_cnt_nxt_s;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_r, bit_cnt_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     miso_r, miso_nxt_s;
    logic                     done_r, done_nxt_s;
    logic                     ovr_r, ovr_nxt_s;
    logic                     start_s;

    // Synchronize cnv/sck and register their edges (edge pulses are one clk wide).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnv_meta_r <= 1'b0; cnv_sync_r <= 1'b0; cnv_prev_r <= 1'b0; cnv_rise_r <= 1'b0;
            sck_meta_r <= 1'b0; sck_sync_r <= 1'b0; sck_prev_r <= 1'b0;
            sck_rise_r <= 1'b0; sck_fall_r <= 1'b0;
        end else begin
            cnv_meta_r <= cnv;
            cnv_sync_r <= cnv_meta_r;
            cnv_prev_r <= cnv_sync_r;
            cnv_rise_r <= cnv_sync_r & ~cnv_prev_r;
            sck_meta_r <= sck;
            sck_sync_r <= sck_meta_r;
            sck_prev_r <= sck_sync_r;
            sck_rise_r <= sck_sync_r & ~sck_prev_r;
            sck_fall_r <= ~sck_sync_r & sck_prev_r;
        end
    end

`ifdef ADC_SIM_TEST_PATTERN_EN
    logic [CHANNEL_DATA_WIDTH-1:0] ramp_r;

    // Ramp advances once per accepted conversion, after being latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_r <= '0;
        end else if (start_s) begin
            ramp_r <= ramp_r + CHANNEL_DATA_WIDTH'(1);
        end else begin
            ramp_r <= ramp_r;
        end
    end

    assign sample_s = {~ramp_r, ramp_r};
`else
    assign sample_s = {ch2_data, ch1_data};
`endif

    assign start_s = cnv_rise_r & ((state_r == ST_IDLE) | (state_r == ST_READY));

    // Next-state and output logic; a CNV rise in READY takes priority over SCK.
    always_comb begin
        state_nxt_s    = state_r;
        shreg_nxt_s    = shreg_r;
        conv_cnt_nxt_s = conv_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        busy_nxt_s     = busy_r;
        miso_nxt_s     = miso_r;
        done_nxt_s     = 1'b0;
        ovr_nxt_s      = 1'b0;
        if (start_s) begin
            shreg_nxt_s    = sample_s;
            busy_nxt_s     = 1'b1;
            miso_nxt_s     = 1'b0;
            conv_cnt_nxt_s = CONV_LOAD;
            bit_cnt_nxt_s  = '0;
            state_nxt_s    = ST_CONVERT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    miso_nxt_s = 1'b0;
                end
                ST_CONVERT: begin
                    miso_nxt_s = 1'b0;
                    ovr_nxt_s  = cnv_rise_r;
                    if (conv_cnt_r == '0) begin
                        busy_nxt_s    = 1'b0;
                        miso_nxt_s    = shreg_r[FRAME_W-1];
                        bit_cnt_nxt_s = '0;
                        state_nxt_s   = ST_READY;
                    end else begin
                        conv_cnt_nxt_s = conv_cnt_r - CONV_W'(1);
                    end
                end
                ST_READY: begin
                    if (sck_rise_r) begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_CNT_WIDTH'(1);
                        state_nxt_s   = ST_SHIFT;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_SHIFT: begin
                    ovr_nxt_s = cnv_rise_r;
                    if (sck_rise_r) begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_CNT_WIDTH'(1);
                        if (bit_cnt_r == BIT_LAST) begin
                            done_nxt_s  = 1'b1;
                            miso_nxt_s  = 1'b0;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_SHIFT;
                        end
                    end else if (sck_fall_r) begin
                        shreg_nxt_s = {shreg_r[FRAME_W-2:0], 1'b0};
                        miso_nxt_s  = shreg_r[FRAME_W-2];
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    miso_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            conv_cnt_r <= '0;
            bit_cnt_r  <= '0;
            busy_r     <= 1'b0;
            miso_r     <= 1'b0;
            done_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shreg_r    <= shreg_nxt_s;
            conv_cnt_r <= conv_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            busy_r     <= busy_nxt_s;
            miso_r     <= miso_nxt_s;
            done_r     <= done_nxt_s;
            ovr_r      <= ovr_nxt_s;
        end
    end

    assign adc_busy   = busy_r;
    assign miso       = miso_r;
    assign frame_done = done_r;
    assign overrun    = ovr_r;
endmodule

// File: tb/tb_adc_sim_responder.sv
// Directed bench for adc_sim_responder: conversion timing, frame content, overrun, reset and over-clocking.
// Honours ADC_SIM_TEST_PATTERN_EN by predicting the ramp instead of port data.
module tb_adc_sim_responder;
    logic        clk = 1'b0;
    logic        rst, cnv, sck;
    logic [17:0] ch1_data, ch2_data;
    logic        adc_busy, miso, frame_done, overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] ramp_exp;
    logic [35:0] ef;
    logic [63:0] bits;
    int          rise_c, fall_c, ovr_cnt, done_cnt;
    logic        miso_f;

    adc_sim_responder dut (
        .clk(clk), .rst(rst), .cnv(cnv), .sck(sck),
        .ch1_data(ch1_data), .ch2_data(ch2_data),
        .adc_busy(adc_busy), .miso(miso), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame for the next accepted conversion; advances the ramp model.
    task automatic next_frame(output logic [35:0] f);
`ifdef ADC_SIM_TEST_PATTERN_EN
        f = {~ramp_exp, ramp_exp};
        ramp_exp = ramp_exp + 18'd1;
`else
        f = {ch2_data, ch1_data};
`endif
    endtask

    task automatic do_conv(input int second_at, input logic [17:0] alt1, input logic [17:0] alt2,
                           output int rc, output int fc, output int oc, output logic mf);
        rc = -1; fc = -1; oc = 0; mf = 1'b0;
        @(negedge clk) cnv = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (overrun) oc++;
            if (adc_busy && rc < 0) rc = c;
            if (!adc_busy && rc >= 0 && fc < 0) begin
                fc = c;
                mf = miso;
            end
            if (c == 1) cnv = 1'b0;
            if (c == second_at) begin
                cnv = 1'b1; ch1_data = alt1; ch2_data = alt2;
            end
            if (c == second_at + 2) cnv = 1'b0;
        end
    endtask

    task automatic spi_read(input int n, output logic [63:0] b, output int dc);
        b = 64'd0; dc = 0;
        for (int i = 0; i < n; i++) begin
            b = {b[62:0], miso};
            sck = 1'b1;
            repeat (6) begin @(negedge clk); if (frame_done) dc++; end
            sck = 1'b0;
            repeat (6) begin @(negedge clk); if (frame_done) dc++; end
        end
        repeat (12) begin @(negedge clk); if (frame_done) dc++; end
    endtask

    initial begin
        rst = 1'b1; cnv = 1'b0; sck = 1'b0; ramp_exp = 18'd0;
        ch1_data = 18'h155AA; ch2_data = 18'h2AA55;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {63'd0, adc_busy}, 64'd0);
        check_val("rst_miso", {63'd0, miso}, 64'd0);
        check_val("rst_done", {63'd0, frame_done}, 64'd0);
        check_val("rst_ovr", {63'd0, overrun}, 64'd0);
        rst = 1'b0;

        // Basic conversion and full frame
        next_frame(ef);
        do_conv(-1, 18'd0, 18'd0, rise_c, fall_c, ovr_cnt, miso_f);
        check_val("busy_rise", 64'(rise_c), 64'd3);
        check_val("busy_fall", 64'(fall_c), 64'd43);
        check_val("miso_first", {63'd0, miso_f}, {63'd0, ef[35]});
        check_val("no_ovr", 64'(ovr_cnt), 64'd0);
        spi_read(36, bits, done_cnt);
        check_val("frame1", bits, {28'd0, ef});
        check_val("done1", 64'(done_cnt), 64'd1);
        check_val("miso_idle", {63'd0, miso}, 64'd0);

        // Overrun during CONVERT; samples change after latch
        ch1_data = 18'h3C0F0; ch2_data = 18'h0F0F1;
        next_frame(ef);
        do_conv(12, 18'h11111, 18'h22222, rise_c, fall_c, ovr_cnt, miso_f);
        check_val("ovr_cnt", 64'(ovr_cnt), 64'd1);
        check_val("ovr_fall", 64'(fall_c), 64'd43);
        spi_read(36, bits, done_cnt);
        check_val("frame_ovr", bits, {28'd0, ef});
        check_val("done_ovr", 64'(done_cnt), 64'd1);

        // Reset mid-frame
        next_frame(ef);
        do_conv(-1, 18'd0, 18'd0, rise_c, fall_c, ovr_cnt, miso_f);
        spi_read(20, bits, done_cnt);
        check_val("partial", bits, {44'd0, ef[35:16]});
        check_val("partial_done", 64'(done_cnt), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", {63'd0, adc_busy}, 64'd0);
        check_val("mid_rst_miso", {63'd0, miso}, 64'd0);
        check_val("mid_rst_done", {63'd0, frame_done}, 64'd0);
        rst = 1'b0; ramp_exp = 18'd0;
        ch1_data = 18'h00001; ch2_data = 18'h20000;
        next_frame(ef);
        do_conv(-1, 18'd0, 18'd0, rise_c, fall_c, ovr_cnt, miso_f);
        spi_read(36, bits, done_cnt);
        check_val("frame_after_rst", bits, {28'd0, ef});
        check_val("done_after_rst", 64'(done_cnt), 64'd1);

        // 40 SCK: trailing bits are zero, single frame_done
        ch1_data = 18'h3FFFF; ch2_data = 18'h12345;
        next_frame(ef);
        do_conv(-1, 18'd0, 18'd0, rise_c, fall_c, ovr_cnt, miso_f);
        spi_read(40, bits, done_cnt);
        check_val("frame40", bits, {24'd0, ef, 4'h0});
        check_val("done40", 64'(done_cnt), 64'd1);

        // Three back-to-back conversions after reset (ramp 0,1,2 in pattern mode)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ramp_exp = 18'd0;
        for (int k = 0; k < 3; k++) begin
            ch1_data = 18'(k * 18'h01357); ch2_data = 18'(18'h3A5C3 - k);
            next_frame(ef);
            do_conv(-1, 18'd0, 18'd0, rise_c, fall_c, ovr_cnt, miso_f);
            spi_read(36, bits, done_cnt);
            check_val($sformatf("seq_frame%0d", k), bits, {28'd0, ef});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
